// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, instruction field positions, opcode and funct codes
package cpu_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 16;
  localparam int OP_W = 6;
  localparam int REG_W = 4;
  localparam int FN_W = 4;
  localparam int IMM_W = 16;
  localparam int OP_LSB = 26;
  localparam int RD_LSB = 22;
  localparam int RS_LSB = 18;
  localparam int RT_LSB = 14;
  localparam int FN_LSB = 0;
  localparam int IMM_LSB = 0;
  localparam logic [OP_W-1:0] OP_R = 6'h00;
  localparam logic [OP_W-1:0] OP_ADDI = 6'h01;
  localparam logic [OP_W-1:0] OP_LW = 6'h02;
  localparam logic [OP_W-1:0] OP_SW = 6'h03;
  localparam logic [OP_W-1:0] OP_BEQ = 6'h04;
  localparam logic [OP_W-1:0] OP_BNE = 6'h05;
  localparam logic [OP_W-1:0] OP_JMP = 6'h06;
  localparam logic [OP_W-1:0] OP_OUT = 6'h07;
  localparam logic [OP_W-1:0] OP_HALT = 6'h3f;
  localparam logic [FN_W-1:0] F_ADD = 4'd0;
  localparam logic [FN_W-1:0] F_SUB = 4'd1;
  localparam logic [FN_W-1:0] F_AND = 4'd2;
  localparam logic [FN_W-1:0] F_OR = 4'd3;
  localparam logic [FN_W-1:0] F_XOR = 4'd4;
  localparam logic [FN_W-1:0] F_SLT = 4'd5;
  localparam logic [FN_W-1:0] F_SLL = 4'd6;
  localparam logic [FN_W-1:0] F_SRL = 4'd7;
  localparam logic [FN_W-1:0] F_SRA = 4'd8;
endpackage

// File: rtl/cpu_alu.sv
// cpu_alu: combinational ALU for R-type ops and address/immediate addition
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [FN_W-1:0] funct,
  output logic [XLEN-1:0] result
);
  always_comb
    result = funct == F_ADD ? a + b :
             funct == F_SUB ? a - b :
             funct == F_AND ? a & b :
             funct == F_OR  ? a | b :
             funct == F_XOR ? a ^ b :
             funct == F_SLT ? {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)} :
             funct == F_SLL ? a << b[4:0] :
             funct == F_SRL ? a >> b[4:0] :
             funct == F_SRA ? XLEN'($signed(a) >>> b[4:0]) : '0;
endmodule

// File: rtl/cpu_core.sv
// cpu_core: single-cycle 32-bit core with ROM, data RAM, 16-entry regfile, OUT register and HALT/continue
module cpu_core
  import cpu_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64,
  parameter string PROG_FILE = "program.hex"
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cont,
  output logic [XLEN-1:0] out
);
  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);
  logic [XLEN-1:0] imem [IMEM_DEPTH];
  logic [XLEN-1:0] dmem [DMEM_DEPTH] = '{default: '0};
  logic [XLEN-1:0] regs [NREG];
  logic [IW-1:0] pc;
  logic halted;
  logic [XLEN-1:0] ins, imm, rd_val, rs_val, rt_val, alu_b, alu_y, pc_ext, pc_n, wr_data;
  logic [OP_W-1:0] op;
  logic [REG_W-1:0] rd, rs, rt;
  logic [FN_W-1:0] funct, alu_f;
  logic [DW-1:0] addr;
  logic wr_en, taken;
  assign ins = imem[pc];
  assign op = ins[OP_LSB +: OP_W];
  assign rd = ins[RD_LSB +: REG_W];
  assign rs = ins[RS_LSB +: REG_W];
  assign rt = ins[RT_LSB +: REG_W];
  assign funct = ins[FN_LSB +: FN_W];
  assign imm = {{(XLEN-IMM_W){ins[IMM_LSB+IMM_W-1]}}, ins[IMM_LSB +: IMM_W]};
  assign rd_val = rd == '0 ? '0 : regs[rd];
  assign rs_val = rs == '0 ? '0 : regs[rs];
  assign rt_val = rt == '0 ? '0 : regs[rt];
  assign alu_b = op == OP_R ? rt_val : imm;
  assign alu_f = op == OP_R ? funct : F_ADD;
  cpu_alu alu (.a(rs_val), .b(alu_b), .funct(alu_f), .result(alu_y));
  assign addr = DW'(alu_y % XLEN'(DMEM_DEPTH));
  assign wr_data = op == OP_LW ? dmem[addr] : alu_y;
  assign wr_en = !halted && rd != '0 && ((op == OP_R && funct <= F_SRA) || op == OP_ADDI || op == OP_LW);
  assign taken = (op == OP_BEQ && rd_val == rs_val) || (op == OP_BNE && rd_val != rs_val);
  assign pc_ext = XLEN'(pc);
  always_comb
    pc_n = halted ? pc_ext + XLEN'(cont) :
           op == OP_HALT ? pc_ext :
           op == OP_JMP ? {{(XLEN-IMM_W){1'b0}}, imm[IMM_W-1:0]} :
           taken ? pc_ext + 1 + imm : pc_ext + 1;
  always_ff @(posedge clk)
    if (reset) begin
      pc <= '0;
      halted <= 1'b0;
      out <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      pc <= IW'(pc_n % XLEN'(IMEM_DEPTH));
      halted <= halted ? !cont : op == OP_HALT;
      if (wr_en) regs[rd] <= wr_data;
      if (!halted && op == OP_OUT) out <= rs_val;
    end
  always_ff @(posedge clk)
    if (!reset && !halted && op == OP_SW) dmem[addr] <= rd_val;
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed programs loaded into the ROM, checking out/pc against hand-computed values
module tb_cpu_core;
  import cpu_pkg::*;
  logic clk, reset, cont;
  logic [31:0] out;
  int n_cmp, n_bad;
  cpu_core #(.IMEM_DEPTH(64), .DMEM_DEPTH(64), .PROG_FILE("")) dut (
    .clk(clk), .reset(reset), .cont(cont), .out(out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] r_ins(int f, int d, int s, int t);
    return {OP_R, 4'(d), 4'(s), 4'(t), 10'b0, 4'(f)};
  endfunction
  function automatic logic [31:0] i_ins(logic [5:0] op, int d, int s, int imm);
    return {op, 4'(d), 4'(s), 2'b0, 16'(imm)};
  endfunction
  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic clear_rom;
    for (int i = 0; i < 64; i++) dut.imem[i] = '0;
  endtask
  task automatic do_reset;
    reset = 1;
    tick();
    reset = 0;
  endtask
  task automatic test_reset;
    clear_rom();
    dut.imem[0] = i_ins(OP_ADDI, 1, 0, 5);
    dut.imem[1] = i_ins(OP_ADDI, 2, 0, 7);
    dut.imem[2] = r_ins(0, 3, 1, 2);
    dut.imem[3] = i_ins(OP_OUT, 0, 3, 0);
    dut.imem[4] = i_ins(OP_HALT, 0, 0, 0);
    reset = 1;
    cont = 1;
    tick();
    reset = 0;
    cont = 0;
    n_cmp++;
    if (out !== 32'd0) begin n_bad++; $display("FAIL reset_out: got %h want %h", out, 32'd0); end
    n_cmp++;
    if (dut.pc !== 6'd0) begin n_bad++; $display("FAIL reset_pc: got %0d want 0", dut.pc); end
  endtask
  task automatic test_add;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++;
      if (out !== 32'd0) begin n_bad++; $display("FAIL add_pre%0d: got %h want 0", k, out); end
    end
    tick();
    n_cmp++;
    if (out !== 32'd12) begin n_bad++; $display("FAIL add_out: got %h want %h", out, 32'd12); end
  endtask
  task automatic test_sw_lw;
    clear_rom();
    dut.imem[0] = i_ins(OP_ADDI, 1, 0, -3);
    dut.imem[1] = i_ins(OP_SW, 1, 0, 4);
    dut.imem[2] = i_ins(OP_LW, 2, 0, 4);
    dut.imem[3] = i_ins(OP_OUT, 0, 2, 0);
    dut.imem[4] = i_ins(OP_HALT, 0, 0, 0);
    do_reset();
    tick(3);
    n_cmp++;
    if (out !== 32'd0) begin n_bad++; $display("FAIL swlw_pre: got %h want 0", out); end
    tick();
    n_cmp++;
    if (out !== 32'hFFFF_FFFD) begin n_bad++; $display("FAIL swlw_out: got %h want fffffffd", out); end
  endtask
  task automatic test_alu;
    clear_rom();
    dut.imem[0] = i_ins(OP_ADDI, 1, 0, 12);
    dut.imem[1] = i_ins(OP_ADDI, 2, 0, 10);
    dut.imem[2] = r_ins(1, 3, 1, 2);
    dut.imem[3] = i_ins(OP_OUT, 0, 3, 0);
    dut.imem[4] = r_ins(2, 3, 1, 2);
    dut.imem[5] = i_ins(OP_OUT, 0, 3, 0);
    dut.imem[6] = r_ins(3, 3, 1, 2);
    dut.imem[7] = i_ins(OP_OUT, 0, 3, 0);
    dut.imem[8] = r_ins(4, 3, 1, 2);
    dut.imem[9] = i_ins(OP_OUT, 0, 3, 0);
    dut.imem[10] = i_ins(OP_ADDI, 4, 0, -16);
    dut.imem[11] = i_ins(OP_ADDI, 5, 0, 2);
    dut.imem[12] = r_ins(7, 3, 4, 5);
    dut.imem[13] = i_ins(OP_OUT, 0, 3, 0);
    dut.imem[14] = i_ins(OP_BEQ, 1, 1, 1);
    dut.imem[15] = i_ins(OP_OUT, 0, 1, 0);
    dut.imem[16] = i_ins(OP_OUT, 0, 2, 0);
    dut.imem[17] = r_ins(9, 3, 1, 2);
    dut.imem[18] = i_ins(OP_OUT, 0, 3, 0);
    dut.imem[19] = i_ins(OP_HALT, 0, 0, 0);
    do_reset();
    tick(4);
    n_cmp++;
    if (out !== 32'd2) begin n_bad++; $display("FAIL alu_sub: got %h want 2", out); end
    tick(2);
    n_cmp++;
    if (out !== 32'd8) begin n_bad++; $display("FAIL alu_and: got %h want 8", out); end
    tick(2);
    n_cmp++;
    if (out !== 32'd14) begin n_bad++; $display("FAIL alu_or: got %h want e", out); end
    tick(2);
    n_cmp++;
    if (out !== 32'd6) begin n_bad++; $display("FAIL alu_xor: got %h want 6", out); end
    tick(4);
    n_cmp++;
    if (out !== 32'h3FFF_FFFC) begin n_bad++; $display("FAIL alu_srl: got %h want 3ffffffc", out); end
    tick();
    n_cmp++;
    if (out !== 32'h3FFF_FFFC) begin n_bad++; $display("FAIL beq_hold: got %h want 3ffffffc", out); end
    tick();
    n_cmp++;
    if (out !== 32'd10) begin n_bad++; $display("FAIL beq_taken: got %h want a", out); end
    tick(2);
    n_cmp++;
    if (out !== 32'h3FFF_FFFC) begin n_bad++; $display("FAIL funct_nop: got %h want 3ffffffc", out); end
  endtask
  task automatic test_loop;
    clear_rom();
    dut.imem[0] = i_ins(OP_ADDI, 1, 0, 10);
    dut.imem[1] = i_ins(OP_ADDI, 2, 0, 0);
    dut.imem[2] = r_ins(0, 2, 2, 1);
    dut.imem[3] = i_ins(OP_ADDI, 1, 1, -1);
    dut.imem[4] = i_ins(OP_BNE, 1, 0, -3);
    dut.imem[5] = i_ins(OP_OUT, 0, 2, 0);
    dut.imem[6] = i_ins(OP_ADDI, 4, 0, -1);
    dut.imem[7] = i_ins(OP_ADDI, 5, 0, 1);
    dut.imem[8] = r_ins(5, 6, 4, 5);
    dut.imem[9] = i_ins(OP_OUT, 0, 6, 0);
    dut.imem[10] = i_ins(OP_ADDI, 7, 0, 1);
    dut.imem[11] = i_ins(OP_ADDI, 8, 0, 31);
    dut.imem[12] = r_ins(6, 7, 7, 8);
    dut.imem[13] = i_ins(OP_ADDI, 9, 0, 4);
    dut.imem[14] = r_ins(8, 10, 7, 9);
    dut.imem[15] = i_ins(OP_OUT, 0, 10, 0);
    dut.imem[16] = i_ins(OP_HALT, 0, 0, 0);
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      tick();
      n_cmp++;
      if (out !== 32'd0) begin n_bad++; $display("FAIL loop_quiet%0d: got %h want 0", k, out); end
    end
    tick();
    n_cmp++;
    if (out !== 32'd55) begin n_bad++; $display("FAIL loop_sum: got %h want 37", out); end
    tick(4);
    n_cmp++;
    if (out !== 32'd1) begin n_bad++; $display("FAIL slt_neg: got %h want 1", out); end
    tick(6);
    n_cmp++;
    if (out !== 32'hF800_0000) begin n_bad++; $display("FAIL sra: got %h want f8000000", out); end
  endtask
  task automatic test_halt;
    clear_rom();
    dut.imem[0] = i_ins(OP_ADDI, 1, 0, 42);
    dut.imem[1] = i_ins(OP_HALT, 0, 0, 0);
    dut.imem[2] = i_ins(OP_OUT, 0, 1, 0);
    dut.imem[3] = i_ins(OP_HALT, 0, 0, 0);
    dut.imem[4] = i_ins(OP_ADDI, 1, 1, 1);
    dut.imem[5] = i_ins(OP_OUT, 0, 1, 0);
    dut.imem[6] = i_ins(OP_HALT, 0, 0, 0);
    do_reset();
    tick(2);
    for (int k = 0; k < 20; k++) begin
      tick();
      n_cmp++;
      if (dut.pc !== 6'd1 || out !== 32'd0) begin
        n_bad++;
        $display("FAIL halt_freeze%0d: got pc=%0d out=%h want pc=1 out=0", k, dut.pc, out);
      end
    end
    cont = 1;
    tick();
    cont = 0;
    n_cmp++;
    if (dut.pc !== 6'd2 || out !== 32'd0) begin
      n_bad++;
      $display("FAIL halt_resume: got pc=%0d out=%h want pc=2 out=0", dut.pc, out);
    end
    cont = 1;
    tick();
    n_cmp++;
    if (out !== 32'd42) begin n_bad++; $display("FAIL halt_out: got %h want 2a", out); end
    tick(2);
    n_cmp++;
    if (dut.pc !== 6'd4 || out !== 32'd42) begin
      n_bad++;
      $display("FAIL halt_2cyc: got pc=%0d out=%h want pc=4 out=2a", dut.pc, out);
    end
    tick(2);
    n_cmp++;
    if (out !== 32'd43) begin n_bad++; $display("FAIL halt_cont_out: got %h want 2b", out); end
    cont = 0;
  endtask
  task automatic test_reset_mid;
    logic [31:0] exp_seq [6];
    exp_seq = '{32'd0, 32'd1, 32'd1, 32'd1, 32'd2, 32'd2};
    clear_rom();
    dut.imem[0] = i_ins(OP_ADDI, 1, 0, 1);
    dut.imem[1] = i_ins(OP_OUT, 0, 1, 0);
    dut.imem[2] = i_ins(OP_ADDI, 1, 1, 1);
    dut.imem[3] = i_ins(OP_JMP, 0, 0, 1);
    do_reset();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 6; k++) begin
        tick();
        n_cmp++;
        if (out !== exp_seq[k]) begin n_bad++; $display("FAIL rerun%0d_t%0d: got %h want %h", r, k + 1, out, exp_seq[k]); end
      end
      if (r == 0) begin
        reset = 1;
        cont = 1;
        tick();
        reset = 0;
        cont = 0;
        n_cmp++;
        if (out !== 32'd0 || dut.pc !== 6'd0) begin
          n_bad++;
          $display("FAIL reset_mid: got out=%h pc=%0d want out=0 pc=0", out, dut.pc);
        end
      end
    end
  endtask
  task automatic test_r0_jmp;
    clear_rom();
    dut.imem[0] = i_ins(OP_ADDI, 1, 0, 77);
    dut.imem[1] = i_ins(OP_OUT, 0, 1, 0);
    dut.imem[2] = i_ins(OP_ADDI, 0, 0, 9);
    dut.imem[3] = i_ins(OP_OUT, 0, 0, 0);
    dut.imem[4] = i_ins(OP_JMP, 0, 0, 63);
    dut.imem[63] = i_ins(OP_OUT, 0, 1, 0);
    do_reset();
    tick(2);
    n_cmp++;
    if (out !== 32'd77) begin n_bad++; $display("FAIL r0_pre: got %h want 4d", out); end
    tick(2);
    n_cmp++;
    if (out !== 32'd0) begin n_bad++; $display("FAIL r0_write: got %h want 0", out); end
    tick();
    n_cmp++;
    if (dut.pc !== 6'd63) begin n_bad++; $display("FAIL jmp_pc: got %0d want 63", dut.pc); end
    tick();
    n_cmp++;
    if (out !== 32'd77 || dut.pc !== 6'd0) begin
      n_bad++;
      $display("FAIL pc_wrap: got out=%h pc=%0d want out=4d pc=0", out, dut.pc);
    end
  endtask
  initial begin
    clk = 0;
    reset = 0;
    cont = 0;
    n_cmp = 0;
    n_bad = 0;
    #2;
    test_reset();
    test_add();
    test_sw_lw();
    test_alu();
    test_loop();
    test_halt();
    test_reset_mid();
    test_r0_jmp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
